// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared constants, state encoding and select-step helper
// Contents: DEFAULT_N, IDLE/SCAN encodings, state_t, next_sel()
package mux_scan_pkg;

    localparam int DEFAULT_N = 4;

    localparam logic IDLE = 1'b0;
    localparam logic SCAN = 1'b1;

    typedef enum logic {
        ST_IDLE = IDLE,
        ST_SCAN = SCAN
    } state_t;

    // Widened to 32 bits so any N can use it; callers truncate back to N bits,
    // which gives the modulo 2**N wrap for free.
    function automatic logic [31:0] next_sel(input logic [31:0] sel, input logic msb_first);
        return msb_first ? (sel - 32'd1) : (sel + 32'd1);
    endfunction

endpackage

// File: rtl/mux_scan_serializer_if.sv
// rtl/mux_scan_serializer_if.sv - load and serial-bit handshake bundle
// Signals: load_valid/load_ready/load_data/load_msb_first (word in),
//          sel/bit_out/bit_valid/bit_ready/last (bit stream out), busy (status)
// Modports: master = serializer side, slave = environment side
interface mux_scan_serializer_if #(
    parameter int N = 4
);
    localparam int W = 2 ** N;

    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] load_data;
    logic         load_msb_first;
    logic [N-1:0] sel;
    logic         bit_out;
    logic         bit_valid;
    logic         bit_ready;
    logic         last;
    logic         busy;

    modport master (
        input  load_valid, load_data, load_msb_first, bit_ready,
        output load_ready, sel, bit_out, bit_valid, last, busy
    );

    modport slave (
        output load_valid, load_data, load_msb_first, bit_ready,
        input  load_ready, sel, bit_out, bit_valid, last, busy
    );

endinterface

// File: rtl/scan_counter.sv
// rtl/scan_counter.sv - N-bit up/down select counter with load, enable and terminal flag
// Ports: clk, rst (sync, active-high), load, load_down (direction captured on load),
//        enable (step one position), count (current index), terminal (end of walk reached)
module scan_counter
    import mux_scan_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         load_down,
    input  logic         enable,
    output logic [N-1:0] count,
    output logic         terminal
);

    logic [N-1:0] cnt_q;
    logic         down_q;

    // Load wins over enable so a word accepted on the final beat restarts the walk.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            down_q <= 1'b0;
        end else if (load) begin
            down_q <= load_down;
            cnt_q  <= load_down ? '1 : '0;
        end else if (enable) begin
            cnt_q  <= N'(next_sel(32'(cnt_q), down_q));
        end
    end

    assign count    = cnt_q;
    assign terminal = down_q ? (cnt_q == '0) : (&cnt_q);

endmodule

// File: rtl/mux_scan_serializer.sv
// rtl/mux_scan_serializer.sv - streams a parallel 2**N-bit word out one bit per beat with its select index
// Ports: clk, rst (sync, active-high), bus (mux_scan_serializer_if.master: load handshake in,
//        sel/bit_out/bit_valid/bit_ready/last stream out, busy)
module mux_scan_serializer
    import mux_scan_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic                  clk,
    input  logic                  rst,
    mux_scan_serializer_if.master bus
);

    localparam int W = 2 ** N;

    state_t       state_q;
    state_t       state_d;
    logic [W-1:0] word_q;
    logic [N-1:0] sel_w;
    logic         term_w;
    logic         load_fire;
    logic         beat;

    assign load_fire = bus.load_valid & bus.load_ready;
    assign beat      = bus.bit_valid & bus.bit_ready;

    // Stepping stops on the last beat so sel keeps its final value in IDLE.
    scan_counter #(.N(N)) u_scan_counter (
        .clk       (clk),
        .rst       (rst),
        .load      (load_fire),
        .load_down (bus.load_msb_first),
        .enable    (beat & ~bus.last),
        .count     (sel_w),
        .terminal  (term_w)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The word is only written on an accepted load, so it is frozen during the walk.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
        end else if (load_fire) begin
            word_q <= bus.load_data;
        end
    end

    always_comb begin
        state_d        = state_q;
        bus.load_ready = 1'b0;
        bus.bit_valid  = 1'b0;
        bus.busy       = 1'b0;
        bus.last       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.load_ready = 1'b1;
                if (bus.load_valid) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                bus.bit_valid  = 1'b1;
                bus.busy       = 1'b1;
                bus.last       = term_w;
                // Opening the load port on the final beat makes back-to-back words seamless.
                bus.load_ready = term_w & bus.bit_ready;
                if (term_w && bus.bit_ready) begin
                    state_d = bus.load_valid ? ST_SCAN : ST_IDLE;
                end
            end
        endcase
    end

    assign bus.sel     = sel_w;
    assign bus.bit_out = word_q[sel_w];

endmodule

// File: tb/tb_mux_scan_serializer.sv
// tb/tb_mux_scan_serializer.sv - self-checking bench for mux_scan_serializer
module tb_mux_scan_serializer;

    localparam int N = 4;
    localparam int W = 16;

    typedef struct {
        logic [15:0] word;
        logic        msb;
        int          stall_sel;
        int          stall_n;
        logic [3:0]  first_sel;
        logic        first_bit;
        int          exp_cycles;
    } vec_t;

    typedef struct {
        logic [3:0] sel;
        logic       b;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   valid_cycles = 0;
    exp_t sb[$];
    vec_t vecs[4];

    logic       hold_pending = 1'b0;
    logic [3:0] h_sel;
    logic       h_bit;
    logic       h_last;

    mux_scan_serializer_if #(.N(N)) bus ();

    mux_scan_serializer #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected beat per accepted bit and checks hold-stability under stall.
    always @(negedge clk) begin
        if (rst) begin
            hold_pending = 1'b0;
        end else begin
            if (bus.bit_valid) valid_cycles++;
            if (hold_pending) begin
                checks++;
                if (!bus.bit_valid || bus.sel !== h_sel || bus.bit_out !== h_bit || bus.last !== h_last) begin
                    failures++;
                    $display("FAIL stall_hold: got v=%0b sel=%0d bit=%0b last=%0b expected v=1 sel=%0d bit=%0b last=%0b",
                             bus.bit_valid, bus.sel, bus.bit_out, bus.last, h_sel, h_bit, h_last);
                end
            end
            hold_pending = bus.bit_valid && !bus.bit_ready;
            h_sel  = bus.sel;
            h_bit  = bus.bit_out;
            h_last = bus.last;
            if (bus.bit_valid && bus.bit_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL beat_unexpected: got sel=%0d with empty scoreboard", bus.sel);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (bus.sel !== e.sel || bus.bit_out !== e.b || bus.last !== e.last) begin
                        failures++;
                        $display("FAIL beat: got sel=%0d bit=%0b last=%0b expected sel=%0d bit=%0b last=%0b",
                                 bus.sel, bus.bit_out, bus.last, e.sel, e.b, e.last);
                    end
                end
            end
        end
    end

    task automatic push_word(input logic [15:0] word, input logic msb);
        for (int i = 0; i < W; i++) begin
            exp_t e;
            e.sel  = msb ? 4'(15 - i) : 4'(i);
            e.b    = word[e.sel];
            e.last = (i == W - 1);
            sb.push_back(e);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic load_word(input logic [15:0] word, input logic msb);
        bus.load_valid     = 1'b1;
        bus.load_data      = word;
        bus.load_msb_first = msb;
        push_word(word, msb);
        #1;
        chk("load_ready_idle", 32'(bus.load_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.load_valid = 1'b0;
        bus.load_data  = 16'h0;
    endtask

    task automatic run_beats(input logic msb, input int stall_sel, input int stall_n, input int nbeats);
        int idx = 0;
        int stalls = stall_n;
        int cyc = 0;
        while (idx < nbeats && cyc < 100) begin
            int s;
            s = msb ? 15 - idx : idx;
            if (s == stall_sel && stalls > 0) begin
                bus.bit_ready = 1'b0;
                stalls--;
            end else begin
                bus.bit_ready = 1'b1;
                idx++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.bit_ready = 1'b1;
        if (idx < nbeats) begin
            checks++;
            failures++;
            $display("FAIL beat_timeout: got %0d beats expected %0d", idx, nbeats);
        end
    endtask

    initial begin
        bus.load_valid     = 1'b1;
        bus.load_data      = 16'hA5A5;
        bus.load_msb_first = 1'b1;
        bus.bit_ready      = 1'b1;

        vecs[0] = '{16'h5ABD, 1'b0, -1, 0, 4'd0,  1'b1, 16};
        vecs[1] = '{16'h5ABD, 1'b1, -1, 0, 4'd15, 1'b0, 16};
        vecs[2] = '{16'h5ABD, 1'b0, 5,  3, 4'd0,  1'b1, 19};
        vecs[3] = '{16'h8001, 1'b1, 0,  2, 4'd15, 1'b1, 18};

        // Reset held two cycles with a pending load
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bit_valid",  32'(bus.bit_valid),  32'd0);
        chk("rst_load_ready", 32'(bus.load_ready), 32'd1);
        chk("rst_sel",        32'(bus.sel),        32'd0);
        chk("rst_busy",       32'(bus.busy),       32'd0);
        chk("rst_last",       32'(bus.last),       32'd0);
        chk("rst_bit_out",    32'(bus.bit_out),    32'd0);
        bus.load_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_after_rst", 32'(bus.bit_valid), 32'd0);

        // Table-driven words
        for (int v = 0; v < 4; v++) begin
            valid_cycles = 0;
            load_word(vecs[v].word, vecs[v].msb);
            chk("first_sel", 32'(bus.sel),     32'(vecs[v].first_sel));
            chk("first_bit", 32'(bus.bit_out), 32'(vecs[v].first_bit));
            chk("first_busy", 32'(bus.busy),   32'd1);
            run_beats(vecs[v].msb, vecs[v].stall_sel, vecs[v].stall_n, W);
            chk("end_bit_valid", 32'(bus.bit_valid), 32'd0);
            chk("end_busy",      32'(bus.busy),      32'd0);
            chk("end_sel_kept",  32'(bus.sel),       vecs[v].msb ? 32'd0 : 32'd15);
            chk("valid_cycles",  32'(valid_cycles),  32'(vecs[v].exp_cycles));
            chk("sb_drained",    32'(sb.size()),     32'd0);
        end

        // Back-to-back: FFFF then 0000 with load_valid held
        begin
            int gap = 0;
            bus.bit_ready      = 1'b1;
            bus.load_valid     = 1'b1;
            bus.load_data      = 16'hFFFF;
            bus.load_msb_first = 1'b0;
            push_word(16'hFFFF, 1'b0);
            @(posedge clk);
            #1;
            bus.load_data = 16'h0000;
            push_word(16'h0000, 1'b0);
            for (int c = 0; c < 32; c++) begin
                @(negedge clk);
                if (!bus.bit_valid) gap++;
                if (c == 15) chk("b2b_load_ready_last", 32'(bus.load_ready), 32'd1);
                if (c == 3)  chk("b2b_load_ready_mid",  32'(bus.load_ready), 32'd0);
                @(posedge clk);
                #1;
                if (c == 15) bus.load_valid = 1'b0;
            end
            chk("b2b_no_bubble",  32'(gap), 32'd0);
            chk("b2b_idle_after", 32'(bus.bit_valid), 32'd0);
            chk("b2b_sb_drained", 32'(sb.size()), 32'd0);
        end

        // Reset in the middle of a scan
        load_word(16'h5ABD, 1'b0);
        run_beats(1'b0, -1, 0, 7);
        chk("pre_rst_sel", 32'(bus.sel), 32'd7);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_bit_valid", 32'(bus.bit_valid), 32'd0);
        chk("midrst_busy",      32'(bus.busy),      32'd0);
        chk("midrst_sel",       32'(bus.sel),       32'd0);
        sb.delete();
        rst = 1'b0;
        load_word(16'h0001, 1'b0);
        chk("post_rst_sel", 32'(bus.sel),     32'd0);
        chk("post_rst_bit", 32'(bus.bit_out), 32'd1);
        run_beats(1'b0, -1, 0, W);
        chk("post_rst_idle", 32'(bus.bit_valid), 32'd0);
        chk("post_rst_sb",   32'(sb.size()),     32'd0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
